// File: rtl/memory_pkg.sv
// Shared sizing constants for the 16x32 memory, its bus bundle and its bench.
package memory_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
endpackage

// File: rtl/mem_interface.sv
// Memory bus bundle: request side (wr/rd/addr/wdata) and registered response side (rdata/response).
interface mem_interface;
  import memory_pkg::*;

  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  response;

  // Master side issues requests; slave side is the RAM.
  modport DRV     (output wr, rd, addr, wdata, input rdata, response);
  modport SLV     (input wr, rd, addr, wdata, output rdata, response);
  modport IN_MON  (input wr, rd, addr, wdata);
  modport OUT_MON (input rdata, response);
endinterface

// File: rtl/ram_32x16.sv
// Single-port synchronous RAM, registered read data and a one-cycle response strobe.
// Read data appears one edge after the request; wr+rd together is rejected (no access, response low).
module ram_32x16
  import memory_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  mem_interface.SLV bus
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  response_q;
  logic                  addr_ok;
  logic                  do_wr;
  logic                  do_rd;

  // Out-of-range check only exists when the array does not fill the address space.
  generate
    if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_partial_range
      assign addr_ok = ({1'b0, bus.addr} < (ADDR_WIDTH + 1)'(DEPTH));
    end
  endgenerate

  assign do_wr = bus.wr & ~bus.rd & addr_ok;
  assign do_rd = bus.rd & ~bus.wr & addr_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata_q    <= '0;
      response_q <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[bus.addr] <= bus.wdata;
      end
      if (do_rd) begin
        rdata_q <= mem[bus.addr];
      end
      response_q <= do_wr | do_rd;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.response = response_q;

endmodule

// File: tb/tb_ram_32x16.sv
// Directed self-checking bench for ram_32x16.
module tb_ram_32x16;
  import memory_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_interface bus ();

  ram_32x16 dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.SLV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one request, then settle 1 time unit past the sampling edge.
  task automatic cycle(input logic w, input logic r, input logic [ADDR_WIDTH-1:0] a,
                       input logic [DATA_WIDTH-1:0] d);
    bus.wr    = w;
    bus.rd    = r;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h want=%h", bus.rdata, 32'h0);
    end
    checks++;
    if (bus.response !== 1'b0) begin
      errors++;
      $display("FAIL reset_response got=%b want=%b", bus.response, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, ADDR_WIDTH'(i), 32'h0);
      checks++;
      if (bus.rdata !== 32'h0 || bus.response !== 1'b1) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h/%b want=%h/1", i, bus.rdata, bus.response, 32'h0);
      end
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL single_write got=%h/%b want=%h/1", bus.rdata, bus.response, 32'h0);
    end
    cycle(1'b0, 1'b1, 4'd3, 32'h0);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_read got=%h/%b want=%h/1", bus.rdata, bus.response, 32'hDEADBEEF);
    end
  endtask

  task automatic test_write_all();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, ADDR_WIDTH'(i), 32'h1000_0000 + i);
      checks++;
      if (bus.response !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL wall_write addr=%0d got=%h/%b want=%h/1", i, bus.rdata, bus.response, 32'hDEADBEEF);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, ADDR_WIDTH'(i), 32'h0);
      checks++;
      if (bus.response !== 1'b1 || bus.rdata !== 32'h1000_0000 + i) begin
        errors++;
        $display("FAIL wall_read addr=%0d got=%h/%b want=%h/1", i, bus.rdata, bus.response, 32'h1000_0000 + i);
      end
    end
  endtask

  task automatic test_alternate();
    cycle(1'b1, 1'b0, 4'd5, 32'hA5A5A5A5);
    cycle(1'b0, 1'b1, 4'd5, 32'h0);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL alt_read1 got=%h/%b want=%h/1", bus.rdata, bus.response, 32'hA5A5A5A5);
    end
    cycle(1'b1, 1'b0, 4'd5, 32'h5A5A5A5A);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL alt_write2 got=%h/%b want=%h/1", bus.rdata, bus.response, 32'hA5A5A5A5);
    end
    cycle(1'b0, 1'b1, 4'd5, 32'h0);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL alt_read2 got=%h/%b want=%h/1", bus.rdata, bus.response, 32'h5A5A5A5A);
    end
  endtask

  task automatic test_illegal_idle();
    cycle(1'b1, 1'b0, 4'd7, 32'h12345678);
    // Park rdata on a different word so a stray read on the illegal cycle is visible.
    cycle(1'b0, 1'b1, 4'd0, 32'h0);
    cycle(1'b1, 1'b1, 4'd7, 32'hFFFFFFFF);
    checks++;
    if (bus.response !== 1'b0 || bus.rdata !== 32'h1000_0000) begin
      errors++;
      $display("FAIL illegal got=%h/%b want=%h/0", bus.rdata, bus.response, 32'h1000_0000);
    end
    cycle(1'b0, 1'b1, 4'd7, 32'h0);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL illegal_readback got=%h/%b want=%h/1", bus.rdata, bus.response, 32'h12345678);
    end
    cycle(1'b0, 1'b0, 4'd2, 32'hFFFFFFFF);
    checks++;
    if (bus.response !== 1'b0 || bus.rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL idle got=%h/%b want=%h/0", bus.rdata, bus.response, 32'h12345678);
    end
    cycle(1'b1, 1'b0, 4'd4, 32'h0);
    checks++;
    if (bus.response !== 1'b1) begin
      errors++;
      $display("FAIL zero_write response got=%b want=1", bus.response);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 4'd9, 32'hCAFEF00D);
    cycle(1'b0, 1'b1, 4'd9, 32'h0);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL async_preread got=%h/%b want=%h/1", bus.rdata, bus.response, 32'hCAFEF00D);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.response !== 1'b0 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_clear got=%h/%b want=%h/0", bus.rdata, bus.response, 32'h0);
    end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    cycle(1'b0, 1'b1, 4'd9, 32'h0);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_readback got=%h/%b want=%h/1", bus.rdata, bus.response, 32'h0);
    end
    cycle(1'b0, 1'b1, 4'd3, 32'h0);
    checks++;
    if (bus.response !== 1'b1 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_cleared3 got=%h/%b want=%h/1", bus.rdata, bus.response, 32'h0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.wr    = 1'b0;
    bus.rd    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    test_reset();
    test_single();
    test_write_all();
    test_alternate();
    test_illegal_idle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
